// File: rtl/module_key_scanner_if.sv
// Keypad-side and key-event signals of module_key_scanner, grouped for the scanner (master)
// and the surrounding logic or bench (slave).
interface module_key_scanner_if;
    logic [3:0] fila_i;
    logic [3:0] colum_o;
    logic [1:0] key_fila_o;
    logic [1:0] key_colum_o;
    logic       key_valid_o;
    logic       key_held_o;
    logic [1:0] dbg_state;

    // key_valid_o is a one-cycle strobe with no ready/back-pressure: the consumer must take the
    // event in that cycle. key_fila_o/key_colum_o are stable while it is high and hold until
    // the next accepted press.
    modport master (
        input  fila_i,
        output colum_o, key_fila_o, key_colum_o, key_valid_o, key_held_o, dbg_state
    );
    modport slave (
        output fila_i,
        input  colum_o, key_fila_o, key_colum_o, key_valid_o, key_held_o, dbg_state
    );
endinterface

// File: rtl/module_key_scanner.sv
// 4x4 keypad column scanner with press/release debounce and a one-cycle key event strobe.
// Optional auto-repeat while a key is held: define KEY_SCAN_REPEAT_EN.
module module_key_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned REPEAT_CYCLES   = 5000000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    module_key_scanner_if.master kp
);
    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("module_key_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_REL} state_t;

    state_t           state, state_n;
    logic [3:0]       row_m, row_s;
    logic [1:0]       col, col_n;
    logic [3:0]       colum_q, colum_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [DEB_W-1:0] deb_cnt, deb_n;
    logic [3:0]       rp, rp_n;
    logic [1:0]       kfila_q, kfila_n;
    logic [1:0]       kcol_q, kcol_n;
    logic             valid_q, valid_n;
    logic             held_q, held_n;

`ifdef KEY_SCAN_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    logic [REP_W-1:0] rep_cnt, rep_n;
`endif

    // Lowest active row wins when several rows read high.
    function automatic logic [1:0] enc_row(input logic [3:0] r);
        if (r[0])      enc_row = 2'd0;
        else if (r[1]) enc_row = 2'd1;
        else if (r[2]) enc_row = 2'd2;
        else           enc_row = 2'd3;
    endfunction

    always_comb begin
        state_n = state;
        col_n   = col;
        div_n   = div_cnt;
        deb_n   = deb_cnt;
        rp_n    = rp;
        kfila_n = kfila_q;
        kcol_n  = kcol_q;
        valid_n = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
        rep_n   = rep_cnt;
`endif
        case (state)
            SCAN: begin
                if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                    div_n = '0;
                    if (row_s != 4'd0) begin
                        rp_n    = row_s;
                        deb_n   = '0;
                        state_n = DEB_PRESS;
                    end else begin
                        col_n = col + 2'd1;
                    end
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            DEB_PRESS: begin
                if (row_s != rp) begin
                    col_n   = col + 2'd1;
                    div_n   = '0;
                    state_n = SCAN;
                end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    kfila_n = enc_row(rp);
                    kcol_n  = col;
                    valid_n = 1'b1;
                    deb_n   = '0;
                    state_n = PRESSED;
`ifdef KEY_SCAN_REPEAT_EN
                    rep_n   = '0;
`endif
                end else begin
                    deb_n = deb_cnt + DEB_W'(1);
                end
            end
            PRESSED: begin
                if (row_s == 4'd0) begin
                    deb_n   = '0;
                    state_n = DEB_REL;
                end
`ifdef KEY_SCAN_REPEAT_EN
                else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                    valid_n = 1'b1;
                    rep_n   = '0;
                end else begin
                    rep_n = rep_cnt + REP_W'(1);
                end
`endif
            end
            DEB_REL: begin
`ifdef KEY_SCAN_REPEAT_EN
                rep_n = '0;
`endif
                if (row_s != 4'd0) begin
                    deb_n   = '0;
                    state_n = PRESSED;
                end else if (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                    col_n   = col + 2'd1;
                    div_n   = '0;
                    state_n = SCAN;
                end else begin
                    deb_n = deb_cnt + DEB_W'(1);
                end
            end
            default: state_n = SCAN;
        endcase
        colum_n = 4'b0001 << col_n;
        held_n  = (state_n == PRESSED) || (state_n == DEB_REL);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= SCAN;
            row_m   <= '0;
            row_s   <= '0;
            col     <= '0;
            colum_q <= 4'b0001;
            div_cnt <= '0;
            deb_cnt <= '0;
            rp      <= '0;
            kfila_q <= '0;
            kcol_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            row_m   <= kp.fila_i;
            row_s   <= row_m;
            state   <= state_n;
            col     <= col_n;
            colum_q <= colum_n;
            div_cnt <= div_n;
            deb_cnt <= deb_n;
            rp      <= rp_n;
            kfila_q <= kfila_n;
            kcol_q  <= kcol_n;
            valid_q <= valid_n;
            held_q  <= held_n;
        end
    end

`ifdef KEY_SCAN_REPEAT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) rep_cnt <= '0;
        else        rep_cnt <= rep_n;
    end
`endif

    assign kp.colum_o     = colum_q;
    assign kp.key_fila_o  = kfila_q;
    assign kp.key_colum_o = kcol_q;
    assign kp.key_valid_o = valid_q;
    assign kp.key_held_o  = held_q;
    assign kp.dbg_state   = state;
endmodule

// File: tb/tb_module_key_scanner.sv
// Bench for module_key_scanner: emulated keypad, event scoreboard and timing checks derived
// from the scan/debounce rules; repeat expectations follow KEY_SCAN_REPEAT_EN.
module tb_module_key_scanner;
    localparam int SCAN_DIV = 8;
    localparam int DEB      = 16;
    localparam int REP      = 50;
`ifdef KEY_SCAN_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  row_v;

    module_key_scanner_if kp_if ();

    module_key_scanner #(
        .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .kp(kp_if)
    );

    always #5 clk = ~clk;

    // Keypad: row r reads high when a pressed key of row r sits on the driven column.
    always_comb begin
        row_v = '0;
        for (int r = 0; r < 4; r++) row_v[r] = |(keys[r*4 +: 4] & kp_if.colum_o);
    end
    assign kp_if.fila_i = row_v;

    int n_checks = 0;
    int n_err    = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int         cyc = 0, ev_cnt = 0, ev_cyc = 0, rep_seen = 0;
    int         col_start = 0, fall_cnt = 0, fall_cyc = 0;
    logic [3:0] fall_col = '0, prev_col = '0;
    logic       prev_valid = 1'b0, prev_held = 1'b0;
    logic [1:0] last_row = '0, last_col = '0;

    always @(negedge clk) begin
        cyc        <= cyc + 1;
        prev_valid <= kp_if.key_valid_o;
        prev_held  <= kp_if.key_held_o;
        prev_col   <= kp_if.colum_o;
        if (kp_if.colum_o != prev_col) col_start <= cyc + 1;
        if (kp_if.key_valid_o === 1'b1) begin
            check("valid_spacing", int'(prev_valid), 0);
            ev_cyc <= cyc + 1;
            if (REP_EN && prev_held) begin
                rep_seen <= rep_seen + 1;
                check("repeat_row", int'(kp_if.key_fila_o), int'(last_row));
                check("repeat_col", int'(kp_if.key_colum_o), int'(last_col));
            end else begin
                ev_cnt   <= ev_cnt + 1;
                last_row <= kp_if.key_fila_o;
                last_col <= kp_if.key_colum_o;
                check("event_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0)
                    check("event_key", int'({kp_if.key_fila_o, kp_if.key_colum_o}), int'(exp_q.pop_front()));
            end
        end
        if (prev_held && !kp_if.key_held_o) begin
            fall_cnt <= fall_cnt + 1;
            fall_cyc <= cyc + 1;
            fall_col <= kp_if.colum_o;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_event(input string tag, input int base, input int budget);
        int n = 0;
        while (ev_cnt <= base && n < budget) begin step(1); n++; end
        check(tag, int'(ev_cnt > base), 1);
    endtask

    task automatic wait_fall(input string tag, input int base, input int budget);
        int n = 0;
        while (fall_cnt <= base && n < budget) begin step(1); n++; end
        check(tag, int'(fall_cnt > base), 1);
    endtask

    task automatic wait_colum(input logic [3:0] target, input int budget);
        int n = 0;
        while (kp_if.colum_o != target && n < budget) begin step(1); n++; end
        check("wait_colum", int'(kp_if.colum_o == target), 1);
    endtask

    function automatic int lowest_row(input logic [3:0] m);
        lowest_row = 0;
        for (int r = 3; r >= 0; r--) if (m[r]) lowest_row = r;
    endfunction

    task automatic press_release(input string tag, input logic [1:0] c, input logic [3:0] m,
                                 input int hold);
        int base, fb, rel;
        base = ev_cnt;
        for (int r = 0; r < 4; r++) if (m[r]) keys[r*4 + int'(c)] = 1'b1;
        exp_q.push_back({2'(lowest_row(m)), c});
        wait_event({tag, "_event"}, base, 150);
        step(hold);
        fb  = fall_cnt;
        rel = cyc;
        keys = '0;
        wait_fall({tag, "_fall"}, fb, 60);
        check({tag, "_release_latency"}, fall_cyc - rel, DEB + 3);
        check({tag, "_resume_col"}, int'(fall_col), int'(4'b0001 << ((c + 1) % 4)));
    endtask

    initial begin
        int base, fb, rel, t, len, rs;
        logic [3:0] exp_c, m;
        logic [1:0] c;
        keys  = '0;
        rst_n = 1'b0;
        step(3);
        check("rst_colum", int'(kp_if.colum_o), 1);
        check("rst_fila", int'(kp_if.key_fila_o), 0);
        check("rst_colidx", int'(kp_if.key_colum_o), 0);
        check("rst_valid", int'(kp_if.key_valid_o), 0);
        check("rst_held", int'(kp_if.key_held_o), 0);
        rst_n = 1'b1;

        // Idle scan: each column dwells SCAN_DIV cycles, rotating upward.
        wait_colum(4'b0010, 20);
        exp_c = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            check("scan_col", int'(kp_if.colum_o), int'(exp_c));
            len = 0;
            while (kp_if.colum_o == exp_c && len < 50) begin step(1); len++; end
            check("scan_dwell", len, SCAN_DIV);
            exp_c = {exp_c[2:0], exp_c[3]};
        end
        check("idle_no_event", ev_cnt, 0);

        // Row 2 on column 1, held 100 cycles.
        wait_colum(4'b0001, 40);
        base = ev_cnt;
        keys[2*4 + 1] = 1'b1;
        exp_q.push_back({2'd2, 2'd1});
        wait_event("press_r2c1", base, 100);
        check("press_latency", ev_cyc - col_start, SCAN_DIV + DEB);
        check("press_held", int'(kp_if.key_held_o), 1);
        step(100);
        check("press_single_pulse", ev_cnt, base + 1);
        check("press_still_held", int'(kp_if.key_held_o), 1);
        check("press_idx_hold", int'({kp_if.key_fila_o, kp_if.key_colum_o}), int'({2'd2, 2'd1}));
        fb = fall_cnt; rel = cyc; keys = '0;
        wait_fall("release_r2c1", fb, 60);
        check("release_latency", fall_cyc - rel, DEB + 3);
        check("release_resume_col", int'(fall_col), int'(4'b0100));

        // Bouncing press of row 0 on column 3.
        wait_colum(4'b1000, 40);
        base = ev_cnt;
        exp_q.push_back({2'd0, 2'd3});
        for (int i = 0; i < 30; i++) begin
            keys[3] = ((i / 3) % 2 == 0);
            step(1);
        end
        keys[3] = 1'b1;
        check("bounce_no_event", ev_cnt, base);
        t = cyc;
        wait_event("bounce_event", base, 150);
        check("bounce_settle", int'(ev_cyc - t >= DEB), 1);
        fb = fall_cnt; keys = '0;
        wait_fall("bounce_fall", fb, 60);

        // Rows 1 and 3 together on column 0: lowest row reported.
        wait_colum(4'b0010, 40);
        press_release("multirow", 2'd0, 4'b1010, 5);

        // Release with a 5-cycle glitch back to pressed.
        base = ev_cnt;
        keys[3*4 + 2] = 1'b1;
        exp_q.push_back({2'd3, 2'd2});
        wait_event("glitch_event", base, 150);
        step(10);
        fb = fall_cnt; keys = '0;
        step(8);
        keys[3*4 + 2] = 1'b1;
        step(5);
        keys = '0; rel = cyc;
        wait_fall("glitch_fall", fb, 60);
        check("glitch_one_fall", fall_cnt, fb + 1);
        check("glitch_release_latency", fall_cyc - rel, DEB + 3);
        check("glitch_no_second_event", ev_cnt, base + 1);

        // Long hold: auto-repeat pulses only when the feature is built in.
        base = ev_cnt; rs = rep_seen;
        keys[0*4 + 1] = 1'b1;
        exp_q.push_back({2'd0, 2'd1});
        wait_event("hold_event", base, 150);
        t = ev_cyc;
        while (cyc < t + 170) step(1);
        fb = fall_cnt; keys = '0;
        wait_fall("hold_fall", fb, 60);
        check("hold_repeats", rep_seen - rs, REP_EN ? 3 : 0);
        check("hold_single_event", ev_cnt, base + 1);

        // Reset while PRESSED.
        base = ev_cnt;
        keys[1*4 + 3] = 1'b1;
        exp_q.push_back({2'd1, 2'd3});
        wait_event("reset_event", base, 150);
        step(5);
        rst_n = 1'b0; keys = '0;
        #1;
        check("midrst_colum", int'(kp_if.colum_o), 1);
        check("midrst_idx", int'({kp_if.key_fila_o, kp_if.key_colum_o}), 0);
        check("midrst_valid", int'(kp_if.key_valid_o), 0);
        check("midrst_held", int'(kp_if.key_held_o), 0);
        step(1);
        rst_n = 1'b1;
        base = ev_cnt;
        step(80);
        check("post_reset_quiet", ev_cnt, base);

        // Random keys and row patterns.
        for (int i = 0; i < 10; i++) begin
            c = 2'($urandom_range(0, 3));
            m = 4'($urandom_range(1, 15));
            press_release("rand", c, m, $urandom_range(0, 30));
            step($urandom_range(0, 20));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
